// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit: fetches aligned words over a valid/ready port and assembles the 6-byte instruction at pc.
// Optional 3-entry recent-word buffer enabled by defining FETCH_WORDBUF_EN.
module y86_fetch_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] pc,
    input  logic        pc_req,
    output logic [47:0] InstrBytes,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        inval
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]  state;
    logic [1:0]  offQ;
    logic [31:0] baseQ;
    logic [31:0] lastAddr;
    logic [2:0]  needQ;
    logic [31:0] words [3];
    logic [31:0] wNext [3];
    logic [31:0] hitData [3];
    logic [1:0]  k;
    logic        start;
    logic        xfer;
    logic [31:0] baseNew;
    logic [2:0]  nMask;
    logic [2:0]  hitMask;
    logic [2:0]  needNew;
    logic [2:0]  needLeft;

    // byte stream is little-endian across words; byte 0 of the window lands in [47:40]
    function automatic logic [47:0] assemble(input logic [95:0] s, input logic [1:0] off);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 6; j++)
            r[47-8*j -: 8] = s[8*(j+int'(off)) +: 8];
        return r;
    endfunction

    assign start       = pc_req && (state == IDLE || (state == VALID && instr_ack));
    assign xfer        = state == FETCH && mem_rvalid;
    assign baseNew     = {pc[31:2], 2'b00};
    assign nMask       = &pc[1:0] ? 3'b111 : 3'b011;
    assign needNew     = nMask & ~hitMask;
    assign k           = needQ[0] ? 2'd0 : needQ[1] ? 2'd1 : 2'd2;
    assign needLeft    = needQ & ~(3'b001 << k);
    assign mem_rd      = state == FETCH;
    assign busy        = state == FETCH;
    assign instr_valid = state == VALID;
    assign mem_addr    = state == FETCH ? baseQ + {28'd0, k, 2'b00} : lastAddr;

    always_comb begin
        for (int i = 0; i < 3; i++)
            wNext[i] = k == 2'(i) ? mem_rdata : words[i];
    end

`ifdef FETCH_WORDBUF_EN
    logic [31:0] bufAddr [3];
    logic [31:0] bufData [3];
    logic [2:0]  bufV;
    logic [1:0]  bufPtr;

    // an inval coinciding with a start forces every word of that fetch to miss
    always_comb begin
        hitMask = '0;
        for (int i = 0; i < 3; i++) begin
            hitData[i] = '0;
            for (int e = 0; e < 3; e++)
                if (!inval && bufV[e] && bufAddr[e] == baseNew + 32'(4*i)) begin
                    hitMask[i] = 1'b1;
                    hitData[i] = bufData[e];
                end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || inval) begin
            bufV   <= '0;
            bufPtr <= '0;
        end else if (xfer) begin
            bufAddr[bufPtr] <= mem_addr;
            bufData[bufPtr] <= mem_rdata;
            bufV[bufPtr]    <= 1'b1;
            bufPtr          <= bufPtr == 2'd2 ? 2'd0 : bufPtr + 2'd1;
        end
    end
`else
    logic unusedInval;
    assign unusedInval = inval;
    assign hitMask     = '0;
    assign hitData     = '{default: '0};
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            InstrBytes <= '0;
            lastAddr   <= '0;
            needQ      <= '0;
            offQ       <= '0;
            baseQ      <= '0;
        end else begin
            lastAddr <= mem_addr;
            if (start) begin
                baseQ <= baseNew;
                offQ  <= pc[1:0];
                needQ <= needNew;
                for (int i = 0; i < 3; i++)
                    words[i] <= hitData[i];
                if (needNew == 3'b000) begin
                    state      <= VALID;
                    InstrBytes <= assemble({hitData[2], hitData[1], hitData[0]}, pc[1:0]);
                end else
                    state <= FETCH;
            end else if (xfer) begin
                words[k] <= mem_rdata;
                needQ    <= needLeft;
                if (needLeft == 3'b000) begin
                    state      <= VALID;
                    InstrBytes <= assemble({wNext[2], wNext[1], wNext[0]}, offQ);
                end
            end else if (state == VALID && instr_ack)
                state <= IDLE;
        end
    end
endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb_y86_fetch_unit: directed checks of the y86 fetch unit against hand-computed values.
module tb_y86_fetch_unit;
`ifdef FETCH_WORDBUF_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] pc;
    logic        pc_req;
    logic [47:0] InstrBytes;
    logic        instr_valid;
    logic        instr_ack;
    logic        busy;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inval;
    logic [31:0] w0;
    logic [31:0] w4;
    int          checks = 0;
    int          errors = 0;
    int          reads = 0;
    int          r0;

    y86_fetch_unit dut (
        .CLK(CLK), .RESET(RESET), .pc(pc), .pc_req(pc_req),
        .InstrBytes(InstrBytes), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .busy(busy), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .inval(inval)
    );

    always #5 CLK = ~CLK;

    // memory: words 0x0/0x4 programmable, elsewhere each byte equals its address low byte
    assign mem_rdata = mem_addr == 32'h0 ? w0 : mem_addr == 32'h4 ? w4 :
                       {mem_addr[7:0] + 8'd3, mem_addr[7:0] + 8'd2, mem_addr[7:0] + 8'd1, mem_addr[7:0]};

    always @(posedge CLK) if (mem_rd && mem_rvalid) reads <= reads + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        RESET = 1'b1; pc = '0; pc_req = 1'b0; instr_ack = 1'b0; inval = 1'b0; mem_rvalid = 1'b1;
        w0 = 32'h00C08030; w4 = 32'h00000004;
        tick(); tick();
        RESET = 1'b0;
        check("rst_valid", instr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_bytes", InstrBytes, 0);

        // aligned fetch, zero-wait
        pc = 32'h0; pc_req = 1'b1; tick(); pc_req = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_rd", mem_rd, 1);
        check("t1_addr0", mem_addr, 32'h0);
        tick();
        check("t1_addr1", mem_addr, 32'h4);
        check("t1_nvalid", instr_valid, 0);
        tick();
        check("t1_valid", instr_valid, 1);
        check("t1_bytes", InstrBytes, 48'h3080C0000400);
        check("t1_rd_off", mem_rd, 0);
        check("t1_addr_hold", mem_addr, 32'h4);
        w0 = 32'h03020100; w4 = 32'h07060504;

        // back-to-back unaligned fetch, n=3
        instr_ack = 1'b1; pc_req = 1'b1; pc = 32'h7; tick(); instr_ack = 1'b0; pc_req = 1'b0;
        check("t2_valid_drop", instr_valid, 0);
        check("t2_busy", busy, 1);
        check("t2_addr0", mem_addr, 32'h4);
        tick();
        check("t2_addr1", mem_addr, 32'h8);
        tick();
        check("t2_addr2", mem_addr, 32'hC);
        check("t2_nvalid", instr_valid, 0);
        tick();
        check("t2_valid", instr_valid, 1);
        check("t2_bytes", InstrBytes, 48'h0708090A0B0C);

        // ack to IDLE, then wait states on word 1
        instr_ack = 1'b1; tick(); instr_ack = 1'b0;
        check("t3_idle", instr_valid, 0);
        check("t3_bytes_keep", InstrBytes, 48'h0708090A0B0C);
        pc = 32'h10; pc_req = 1'b1; tick(); pc_req = 1'b0;
        check("t3_addr0", mem_addr, 32'h10);
        tick();
        check("t3_addr1a", mem_addr, 32'h14);
        mem_rvalid = 1'b0; tick();
        check("t3_addr1b", mem_addr, 32'h14);
        check("t3_wait_valid", instr_valid, 0);
        tick();
        check("t3_addr1c", mem_addr, 32'h14);
        mem_rvalid = 1'b1; tick();
        check("t3_valid", instr_valid, 1);
        check("t3_bytes", InstrBytes, 48'h101112131415);
        pc = 32'h99; pc_req = 1'b1; tick(); tick(); pc_req = 1'b0;
        check("t3_hold_valid", instr_valid, 1);
        check("t3_hold_bytes", InstrBytes, 48'h101112131415);
        check("t3_hold_rd", mem_rd, 0);

        // address wrap
        instr_ack = 1'b1; tick(); instr_ack = 1'b0;
        pc = 32'hFFFFFFFE; pc_req = 1'b1; tick(); pc_req = 1'b0;
        check("t4_addr0", mem_addr, 32'hFFFFFFFC);
        tick();
        check("t4_addr1", mem_addr, 32'h0);
        tick();
        check("t4_valid", instr_valid, 1);
        check("t4_bytes", InstrBytes, 48'hFEFF00010203);

        // reset during second-word wait
        instr_ack = 1'b1; tick(); instr_ack = 1'b0;
        pc = 32'h20; pc_req = 1'b1; tick(); pc_req = 1'b0;
        check("t5_addr0", mem_addr, 32'h20);
        tick();
        mem_rvalid = 1'b0; tick();
        check("t5_wait_rd", mem_rd, 1);
        check("t5_wait_addr", mem_addr, 32'h24);
        RESET = 1'b1; tick(); RESET = 1'b0; mem_rvalid = 1'b1;
        check("t5_rd", mem_rd, 0);
        check("t5_busy", busy, 0);
        check("t5_valid", instr_valid, 0);
        check("t5_bytes", InstrBytes, 0);
        check("t5_addr", mem_addr, 0);
        tick(); tick();
        check("t5_late_valid", instr_valid, 0);
        check("t5_late_rd", mem_rd, 0);

        // word buffer reuse and invalidate
        pc = 32'h0; pc_req = 1'b1; tick(); pc_req = 1'b0;
        tick(); tick();
        check("t6_valid0", instr_valid, 1);
        check("t6_bytes0", InstrBytes, 48'h000102030405);
        r0 = reads;
        instr_ack = 1'b1; pc_req = 1'b1; pc = 32'h2; tick(); instr_ack = 1'b0; pc_req = 1'b0;
        check("t6_hit_valid", instr_valid, 64'(WB));
        check("t6_hit_rd", mem_rd, 64'(!WB));
        tick(); tick();
        check("t6_valid1", instr_valid, 1);
        check("t6_bytes1", InstrBytes, 48'h020304050607);
        check("t6_reads1", 64'(reads - r0), WB ? 64'd0 : 64'd2);
        r0 = reads;
        instr_ack = 1'b1; pc_req = 1'b1; pc = 32'h2; inval = 1'b1; tick();
        instr_ack = 1'b0; pc_req = 1'b0; inval = 1'b0;
        check("t6_inval_rd", mem_rd, 1);
        tick(); tick();
        check("t6_valid2", instr_valid, 1);
        check("t6_reads2", 64'(reads - r0), 64'd2);
        check("t6_bytes2", InstrBytes, 48'h020304050607);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/y86_fetch_unit.md
# y86_fetch_unit

Instruction fetch stage sitting directly upstream of the y86 CPU datapath. Takes the PC the CPU presents, reads the required aligned 32-bit words from a word-wide instruction memory through a valid/ready read port, and assembles the 6 instruction bytes at that PC into the 48-bit `InstrBytes` bus the decoder splits. It holds the assembled instruction stable until the CPU acknowledges it. Memory latency is therefore hidden from the single-cycle datapath behind a valid/ack handshake.

## Interface
Parameters:
- none (widths fixed by the y86 ISA: 32-bit PC, 48-bit instruction window)

Ports:
- `CLK`  in  1  single clock; all state changes on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `pc`  in  32  byte address of the instruction to fetch
- `pc_req`  in  1  start a fetch at `pc`; sampled only when a new fetch may start (see Operation)
- `InstrBytes`  out  48  assembled instruction; byte at `pc` in [47:40], `pc+5` in [7:0]
- `instr_valid`  out  1  `InstrBytes` holds a complete instruction for the captured PC
- `instr_ack`  in  1  CPU consumed `InstrBytes`; meaningful only while `instr_valid`
- `busy`  out  1  high in FETCH state
- `mem_addr`  out  32  word address, bits [1:0] always 0
- `mem_rd`  out  1  read request
- `mem_rvalid`  in  1  memory has `mem_rdata` for `mem_addr`; transfer occurs on a cycle with `mem_rd && mem_rvalid`
- `mem_rdata`  in  32  little-endian: byte at `mem_addr` in [7:0], `mem_addr+3` in [31:24]
- `inval`  in  1  invalidate word buffer (used only with `FETCH_WORDBUF_EN`)

## Operation
- States: IDLE, FETCH, VALID. Reset state IDLE.
- Start condition: (IDLE && `pc_req`) or (VALID && `instr_ack` && `pc_req`). On that edge: capture `pc` into `pc_q`, compute base = {`pc`[31:2],2'b00}, word count n = 3 if `pc`[1:0]==3 else 2, word index k = 0, go to FETCH.
- `pc_req` in FETCH, or in VALID without `instr_ack`, is ignored; the requester must hold it.
- FETCH: `mem_rd`=1, `mem_addr` = base + 4·k (mod 2^32; wrap from 0xFFFFFFFC to 0x00000000 is legal). On `mem_rvalid`: store word k, k++. After word n−1 stored: assemble, go to VALID.
- Assembly: concatenate stored words little-endian into a byte stream; select 6 bytes starting at offset `pc_q`[1:0]; byte 0 → [47:40].
- VALID: `instr_valid`=1, `InstrBytes` stable. `instr_ack` without start condition → IDLE, `instr_valid` drops next cycle; `InstrBytes` keeps its last value until the next assembly.
- `mem_rd` is 0 in IDLE and VALID. `mem_addr` holds its last value outside FETCH.
- Reset values: `InstrBytes`=0, `instr_valid`=0, `busy`=0, `mem_rd`=0, `mem_addr`=0; word buffer (if compiled) all invalid.
- RESET mid-FETCH: fetch aborted; `mem_rd` low on the cycle after the reset edge; a `mem_rvalid` arriving later is ignored. RESET wins over every other input.

## Timing
- Zero-wait memory (`mem_rvalid` tied high): start edge at cycle 0; FETCH cycles 1..n; `instr_valid` high from cycle n+1. Latency 3 cycles (n=2) or 4 cycles (n=3).
- Each wait cycle (`mem_rd` && !`mem_rvalid`) adds exactly one cycle; `mem_addr` stable during waits.
- Back-to-back: ack+req in VALID at edge E → FETCH at E+1, `instr_valid` low at E+1; no idle bubble.
- At most one outstanding read; no read issued outside FETCH.

## Configuration
- `FETCH_WORDBUF_EN` defined: 3-entry buffer of (word address, data, valid), filled on every memory transfer (replace oldest entry). On start, words whose address hits a valid entry are taken from the buffer and skipped in FETCH. If all n words hit: go directly to VALID, `instr_valid` high one cycle after the start edge, no `mem_rd`. `inval` (or RESET) clears all valid bits on that edge; `inval` coinciding with a start edge forces all misses for that fetch.
- Not defined: every fetch reads all n words from memory; `inval` ignored; no buffer storage synthesized.

## Test plan
- Zero-wait, mem word 0x0=0x00C08030, 0x4=0x00000004; `pc`=0, `pc_req` → reads 0x0, 0x4; `InstrBytes`=0x3080C0000400, `instr_valid` at cycle 3.
- Unaligned `pc`=0x7, n=3: `mem_addr` sequence 0x4, 0x8, 0xC; `InstrBytes` = bytes 0x7..0xC; `instr_valid` at cycle 4.
- `mem_rvalid` low 2 cycles on word 1: `mem_addr` held at base+4 for 3 cycles; `instr_valid` at cycle 5; `InstrBytes` unchanged until `instr_ack`.
- Wrap: `pc`=0xFFFFFFFE → `mem_addr` 0xFFFFFFFC then 0x00000000; bytes FE,FF,00,01,02,03 assembled correctly.
- RESET asserted during second word wait → next cycle `mem_rd`=0, IDLE, `instr_valid`=0, `InstrBytes`=0; late `mem_rvalid` has no effect.
- With `FETCH_WORDBUF_EN`: fetch `pc`=0, ack, refetch `pc`=2 → no `mem_rd`, `instr_valid` one cycle after start; assert `inval`, refetch `pc`=2 → two memory reads.
